// File: rtl/mc_control_fsm_if.sv
// ----------------------------------------------------------------------------
// mc_control_fsm_if
//   Control bundle between the multi-cycle MIPS main controller and the
//   datapath.
//   master : the controller. It consumes the instruction fields and ALU flags
//            and drives every mux select and write enable.
//   slave  : the datapath side.
// ----------------------------------------------------------------------------
interface mc_control_fsm_if;
    logic [5:0] OpCode;      // IR[31:26]
    logic [5:0] Funct;       // IR[5:0]
    logic       Zero;        // ALU result == 0
    logic       overflow;    // ALU raw overflow
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic       ExtOp;
    logic       LuiOp;
    logic [4:0] ALUConf;
    logic       Sign;
    logic       ovf_exc;
    logic       illegal_op;

    modport master (
        input  OpCode, Funct, Zero, overflow,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst,
               MemtoReg, ALUSrcA, ALUSrcB, PCSource, ExtOp, LuiOp, ALUConf,
               Sign, ovf_exc, illegal_op
    );

    modport slave (
        output OpCode, Funct, Zero, overflow,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst,
               MemtoReg, ALUSrcA, ALUSrcB, PCSource, ExtOp, LuiOp, ALUConf,
               Sign, ovf_exc, illegal_op
    );
endinterface

// File: rtl/mc_control_fsm.sv
// ----------------------------------------------------------------------------
// mc_control_fsm
//   Multi-cycle MIPS main controller (Moore). Each instruction is sequenced
//   through IF -> ID -> execute -> (memory) -> (writeback).
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-high; forces INIT, where every output is 0
//     bus   - mc_control_fsm_if.master: OpCode/Funct/Zero/overflow in, all
//             datapath controls out
//   Outputs decode the state, the latched overflow bit and OpCode/Funct.
// ----------------------------------------------------------------------------
module mc_control_fsm (
    input  logic                   clk,
    input  logic                   reset,
    mc_control_fsm_if.master       bus
);
    typedef enum logic [3:0] {
        S_INIT, S_IF, S_ID, S_MADDR, S_MRD, S_MWB, S_MWR,
        S_REX, S_RWB, S_IEX, S_IWB, S_BR, S_JMP, S_JR
    } state_t;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_XOR = 5'b01101;
    localparam logic [4:0] ALU_NOR = 5'b01100;
    localparam logic [4:0] ALU_SLT = 5'b00111;
    localparam logic [4:0] ALU_SLL = 5'b11001;
    localparam logic [4:0] ALU_SRL = 5'b10000;
    localparam logic [4:0] ALU_SRA = 5'b11000;

    state_t     r_state;
    state_t     w_next;
    logic       r_ovf_q;
    logic       w_ovf_d;
    logic [4:0] w_conf;
    logic       w_sign;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_INIT;
            r_ovf_q <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ovf_q <= w_ovf_d;
        end
    end

    // Only signed add/sub can trap; address, PC+4, unsigned and logical
    // operations are never flagged.
    assign w_ovf_d = ((r_state == S_REX) || (r_state == S_IEX)) &&
                     bus.overflow && w_sign &&
                     ((w_conf == ALU_ADD) || (w_conf == ALU_SUB));

    assign bus.ALUConf = w_conf;
    assign bus.Sign    = w_sign;

    always_comb begin
        w_next         = S_IF;
        w_conf         = ALU_ADD;
        w_sign         = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.IorD       = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.RegDst     = 2'd0;
        bus.MemtoReg   = 2'd0;
        bus.ALUSrcA    = 2'd0;
        bus.ALUSrcB    = 2'd0;
        bus.PCSource   = 2'd0;
        bus.ExtOp      = 1'b0;
        bus.LuiOp      = 1'b0;
        bus.ovf_exc    = 1'b0;
        bus.illegal_op = 1'b0;

        case (r_state)
            S_INIT: w_next = S_IF;
            S_IF: begin
                bus.MemRead = 1'b1;
                bus.IRWrite = 1'b1;
                bus.ALUSrcB = 2'd1;
                bus.PCWrite = 1'b1;
                w_next      = S_ID;
            end
            S_ID: begin
                // Branch target PC+4 + (imm<<2) is precomputed into ALUOut.
                bus.ALUSrcB = 2'd3;
                bus.ExtOp   = 1'b1;
                case (bus.OpCode)
                    6'h23, 6'h2b: w_next = S_MADDR;
                    6'h00:        w_next = ((bus.Funct == 6'h08) || (bus.Funct == 6'h09)) ? S_JR : S_REX;
                    6'h04:        w_next = S_BR;
                    6'h02, 6'h03: w_next = S_JMP;
                    6'h08, 6'h09, 6'h0a, 6'h0b,
                    6'h0c, 6'h0d, 6'h0e, 6'h0f: w_next = S_IEX;
                    default: begin
                        bus.illegal_op = 1'b1;
                        w_next         = S_IF;
                    end
                endcase
            end
            S_MADDR: begin
                bus.ALUSrcA = 2'd1;
                bus.ALUSrcB = 2'd2;
                bus.ExtOp   = 1'b1;
                w_next      = (bus.OpCode == 6'h23) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                w_next      = S_MWB;
            end
            S_MWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 2'd1;
            end
            S_MWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            S_REX: begin
                bus.ALUSrcA = 2'd1;
                w_next      = S_RWB;
                case (bus.Funct)
                    6'h20, 6'h21: begin w_conf = ALU_ADD; w_sign = (bus.Funct == 6'h20); end
                    6'h22, 6'h23: begin w_conf = ALU_SUB; w_sign = (bus.Funct == 6'h22); end
                    6'h24:        w_conf = ALU_AND;
                    6'h25:        w_conf = ALU_OR;
                    6'h26:        w_conf = ALU_XOR;
                    6'h27:        w_conf = ALU_NOR;
                    6'h2a, 6'h2b: begin w_conf = ALU_SLT; w_sign = (bus.Funct == 6'h2a); end
                    6'h00:        begin w_conf = ALU_SLL; bus.ALUSrcA = 2'd2; end
                    6'h02:        begin w_conf = ALU_SRL; bus.ALUSrcA = 2'd2; end
                    6'h03:        begin w_conf = ALU_SRA; bus.ALUSrcA = 2'd2; end
                    default: begin
                        bus.illegal_op = 1'b1;
                        w_next         = S_IF;
                    end
                endcase
            end
            S_RWB: begin
                bus.RegDst   = 2'd1;
                bus.RegWrite = ~r_ovf_q;
                bus.ovf_exc  = r_ovf_q;
            end
            S_IEX: begin
                bus.ALUSrcA = 2'd1;
                bus.ALUSrcB = 2'd2;
                w_next      = S_IWB;
                case (bus.OpCode)
                    6'h08:   begin w_conf = ALU_ADD; bus.ExtOp = 1'b1; w_sign = 1'b1; end
                    6'h09:   begin w_conf = ALU_ADD; bus.ExtOp = 1'b1; end
                    6'h0c:   w_conf = ALU_AND;
                    6'h0d:   w_conf = ALU_OR;
                    6'h0e:   w_conf = ALU_XOR;
                    6'h0a:   begin w_conf = ALU_SLT; bus.ExtOp = 1'b1; w_sign = 1'b1; end
                    6'h0b:   begin w_conf = ALU_SLT; bus.ExtOp = 1'b1; end
                    // lui: rs is $0 in the encoding, so A + {imm,16'h0} is the result.
                    default: begin w_conf = ALU_ADD; bus.LuiOp = 1'b1; end
                endcase
            end
            S_IWB: begin
                bus.RegWrite = ~r_ovf_q;
                bus.ovf_exc  = r_ovf_q;
            end
            S_BR: begin
                bus.ALUSrcA  = 2'd1;
                w_conf       = ALU_SUB;
                bus.PCSource = 2'd1;
                bus.PCWrite  = bus.Zero;
            end
            S_JMP: begin
                bus.PCSource = 2'd2;
                bus.PCWrite  = 1'b1;
                if (bus.OpCode == 6'h03) begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = 2'd2;
                    bus.MemtoReg = 2'd2;
                end
            end
            S_JR: begin
                bus.PCSource = 2'd3;
                bus.PCWrite  = 1'b1;
                if (bus.Funct == 6'h09) begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = 2'd1;
                    bus.MemtoReg = 2'd2;
                end
            end
            default: w_next = S_INIT;
        endcase
    end
endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mc_control_fsm_if bus();

    mc_control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        ov;
        logic [25:0] exp;
        string       nm;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Pack expected outputs in a fixed field order.
    function automatic logic [25:0] E(
        input logic pcw, input logic iord, input logic mr, input logic mw,
        input logic irw, input logic rw, input logic [1:0] rd,
        input logic [1:0] m2r, input logic [1:0] sa, input logic [1:0] sb,
        input logic [1:0] ps, input logic ext, input logic lui,
        input logic [4:0] conf, input logic sgn, input logic ovx,
        input logic ill);
        return {pcw, iord, mr, mw, irw, rw, rd, m2r, sa, sb, ps, ext, lui,
                conf, sgn, ovx, ill};
    endfunction

    function automatic logic [25:0] act();
        return {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.ALUSrcA,
                bus.ALUSrcB, bus.PCSource, bus.ExtOp, bus.LuiOp, bus.ALUConf,
                bus.Sign, bus.ovf_exc, bus.illegal_op};
    endfunction

    task automatic chk(input string nm, input logic [25:0] got, input logic [25:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic r(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic ov, input logic [25:0] exp, input string nm);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.ov = ov; v.exp = exp; v.nm = nm;
        tbl.push_back(v);
    endtask

    logic [25:0] X_IF, X_ID, X_IDILL, X_ZERO, X_MADDR, X_RWB_OK, X_IWB_OK;

    task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input string nm);
        r(op, fn, 1'b0, 1'b0, X_IF, {nm, "_if"});
        r(op, fn, 1'b0, 1'b0, X_ID, {nm, "_id"});
    endtask

    initial begin
        X_ZERO   = '0;
        X_IF     = E(1,0,1,0,1,0, 2'd0,2'd0, 2'd0,2'd1,2'd0, 0,0, 5'b00000, 0,0,0);
        X_ID     = E(0,0,0,0,0,0, 2'd0,2'd0, 2'd0,2'd3,2'd0, 1,0, 5'b00000, 0,0,0);
        X_IDILL  = E(0,0,0,0,0,0, 2'd0,2'd0, 2'd0,2'd3,2'd0, 1,0, 5'b00000, 0,0,1);
        X_MADDR  = E(0,0,0,0,0,0, 2'd0,2'd0, 2'd1,2'd2,2'd0, 1,0, 5'b00000, 0,0,0);
        X_RWB_OK = E(0,0,0,0,0,1, 2'd1,2'd0, 2'd0,2'd0,2'd0, 0,0, 5'b00000, 0,0,0);
        X_IWB_OK = E(0,0,0,0,0,1, 2'd0,2'd0, 2'd0,2'd0,2'd0, 0,0, 5'b00000, 0,0,0);

        // Row 0 is the INIT cycle right after reset release; one row per cycle.
        r(6'h23, 6'h00, 0, 0, X_ZERO, "init");
        // lw: IF ID MADDR MRD MWB, next IF on the 6th cycle
        fetch(6'h23, 6'h00, "lw");
        r(6'h23, 6'h00, 0, 0, X_MADDR, "lw_maddr");
        r(6'h23, 6'h00, 0, 0, E(0,1,1,0,0,0, 2'd0,2'd0, 2'd0,2'd0,2'd0, 0,0, 5'b00000, 0,0,0), "lw_mrd");
        r(6'h23, 6'h00, 0, 0, E(0,0,0,0,0,1, 2'd0,2'd1, 2'd0,2'd0,2'd0, 0,0, 5'b00000, 0,0,0), "lw_mwb");
        // sw
        fetch(6'h2b, 6'h00, "sw");
        r(6'h2b, 6'h00, 0, 0, X_MADDR, "sw_maddr");
        r(6'h2b, 6'h00, 0, 0, E(0,1,0,1,0,0, 2'd0,2'd0, 2'd0,2'd0,2'd0, 0,0, 5'b00000, 0,0,0), "sw_mwr");
        // add overflowing; overflow drops in RWB and must be ignored
        fetch(6'h00, 6'h20, "add");
        r(6'h00, 6'h20, 0, 1, E(0,0,0,0,0,0, 2'd0,2'd0, 2'd1,2'd0,2'd0, 0,0, 5'b00000, 1,0,0), "add_rex");
        r(6'h00, 6'h20, 0, 0, E(0,0,0,0,0,0, 2'd1,2'd0, 2'd0,2'd0,2'd0, 0,0, 5'b00000, 0,1,0), "add_rwb");
        // addu, same flags: no trap; overflow rising in RWB is ignored
        fetch(6'h00, 6'h21, "addu");
        r(6'h00, 6'h21, 0, 1, E(0,0,0,0,0,0, 2'd0,2'd0, 2'd1,2'd0,2'd0, 0,0, 5'b00000, 0,0,0), "addu_rex");
        r(6'h00, 6'h21, 0, 1, X_RWB_OK, "addu_rwb");
        // sub overflowing
        fetch(6'h00, 6'h22, "sub");
        r(6'h00, 6'h22, 0, 1, E(0,0,0,0,0,0, 2'd0,2'd0, 2'd1,2'd0,2'd0, 0,0, 5'b00110, 1,0,0), "sub_rex");
        r(6'h00, 6'h22, 0, 0, E(0,0,0,0,0,0, 2'd1,2'd0, 2'd0,2'd0,2'd0, 0,0, 5'b00000, 0,1,0), "sub_rwb");
        // slt is signed but never traps
        fetch(6'h00, 6'h2a, "slt");
        r(6'h00, 6'h2a, 0, 1, E(0,0,0,0,0,0, 2'd0,2'd0, 2'd1,2'd0,2'd0, 0,0, 5'b00111, 1,0,0), "slt_rex");
        r(6'h00, 6'h2a, 0, 0, X_RWB_OK, "slt_rwb");
        // sra
        fetch(6'h00, 6'h03, "sra");
        r(6'h00, 6'h03, 0, 1, E(0,0,0,0,0,0, 2'd0,2'd0, 2'd2,2'd0,2'd0, 0,0, 5'b11000, 0,0,0), "sra_rex");
        r(6'h00, 6'h03, 0, 0, X_RWB_OK, "sra_rwb");
        // addi overflowing
        fetch(6'h08, 6'h00, "addi");
        r(6'h08, 6'h00, 0, 1, E(0,0,0,0,0,0, 2'd0,2'd0, 2'd1,2'd2,2'd0, 1,0, 5'b00000, 1,0,0), "addi_iex");
        r(6'h08, 6'h00, 0, 0, E(0,0,0,0,0,0, 2'd0,2'd0, 2'd0,2'd0,2'd0, 0,0, 5'b00000, 0,1,0), "addi_iwb");
        // addiu with overflow flag: no trap
        fetch(6'h09, 6'h00, "addiu");
        r(6'h09, 6'h00, 0, 1, E(0,0,0,0,0,0, 2'd0,2'd0, 2'd1,2'd2,2'd0, 1,0, 5'b00000, 0,0,0), "addiu_iex");
        r(6'h09, 6'h00, 0, 0, X_IWB_OK, "addiu_iwb");
        // sltiu
        fetch(6'h0b, 6'h00, "sltiu");
        r(6'h0b, 6'h00, 0, 0, E(0,0,0,0,0,0, 2'd0,2'd0, 2'd1,2'd2,2'd0, 1,0, 5'b00111, 0,0,0), "sltiu_iex");
        r(6'h0b, 6'h00, 0, 0, X_IWB_OK, "sltiu_iwb");
        // lui
        fetch(6'h0f, 6'h00, "lui");
        r(6'h0f, 6'h00, 0, 0, E(0,0,0,0,0,0, 2'd0,2'd0, 2'd1,2'd2,2'd0, 0,1, 5'b00000, 0,0,0), "lui_iex");
        r(6'h0f, 6'h00, 0, 0, X_IWB_OK, "lui_iwb");
        // ori
        fetch(6'h0d, 6'h00, "ori");
        r(6'h0d, 6'h00, 0, 0, E(0,0,0,0,0,0, 2'd0,2'd0, 2'd1,2'd2,2'd0, 0,0, 5'b00001, 0,0,0), "ori_iex");
        r(6'h0d, 6'h00, 0, 0, X_IWB_OK, "ori_iwb");
        // beq taken / not taken
        fetch(6'h04, 6'h00, "beq1");
        r(6'h04, 6'h00, 1, 0, E(1,0,0,0,0,0, 2'd0,2'd0, 2'd1,2'd0,2'd1, 0,0, 5'b00110, 0,0,0), "beq_taken");
        fetch(6'h04, 6'h00, "beq0");
        r(6'h04, 6'h00, 0, 0, E(0,0,0,0,0,0, 2'd0,2'd0, 2'd1,2'd0,2'd1, 0,0, 5'b00110, 0,0,0), "beq_not_taken");
        // jumps
        fetch(6'h02, 6'h00, "j");
        r(6'h02, 6'h00, 0, 0, E(1,0,0,0,0,0, 2'd0,2'd0, 2'd0,2'd0,2'd2, 0,0, 5'b00000, 0,0,0), "j_jmp");
        fetch(6'h03, 6'h00, "jal");
        r(6'h03, 6'h00, 0, 0, E(1,0,0,0,0,1, 2'd2,2'd2, 2'd0,2'd0,2'd2, 0,0, 5'b00000, 0,0,0), "jal_jmp");
        fetch(6'h00, 6'h08, "jr");
        r(6'h00, 6'h08, 0, 0, E(1,0,0,0,0,0, 2'd0,2'd0, 2'd0,2'd0,2'd3, 0,0, 5'b00000, 0,0,0), "jr_jr");
        fetch(6'h00, 6'h09, "jalr");
        r(6'h00, 6'h09, 0, 0, E(1,0,0,0,0,1, 2'd1,2'd2, 2'd0,2'd0,2'd3, 0,0, 5'b00000, 0,0,0), "jalr_jr");
        // illegal opcode: IF, ID(pulse), back to IF
        r(6'h3f, 6'h00, 0, 0, X_IF, "ill_if");
        r(6'h3f, 6'h00, 0, 0, X_IDILL, "ill_id");
        // illegal funct: pulse in REX, back to IF
        fetch(6'h00, 6'h3f, "illfn");
        r(6'h00, 6'h3f, 0, 0, E(0,0,0,0,0,0, 2'd0,2'd0, 2'd1,2'd0,2'd0, 0,0, 5'b00000, 0,0,1), "illfn_rex");
        r(6'h23, 6'h00, 0, 0, X_IF, "lw2_if");

        // Reset held: everything reads 0.
        bus.OpCode = 6'h23; bus.Funct = 6'h00; bus.Zero = 1'b1; bus.overflow = 1'b1;
        #2 chk("reset_t0", act(), X_ZERO);
        @(negedge clk); #1 chk("reset_held", act(), X_ZERO);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            if (i > 0) @(negedge clk);
            bus.OpCode   = tbl[i].op;
            bus.Funct    = tbl[i].fn;
            bus.Zero     = tbl[i].z;
            bus.overflow = tbl[i].ov;
            #1 chk(tbl[i].nm, act(), tbl[i].exp);
        end

        // lw continues to MRD, then reset arrives mid-cycle.
        @(negedge clk); #1 chk("lw2_id", act(), X_ID);
        @(negedge clk); #1 chk("lw2_maddr", act(), X_MADDR);
        @(negedge clk); #1 chk("lw2_mrd", act(),
            E(0,1,1,0,0,0, 2'd0,2'd0, 2'd0,2'd0,2'd0, 0,0, 5'b00000, 0,0,0));
        #1 reset = 1'b1;
        #1 chk("reset_async", act(), X_ZERO);
        @(negedge clk); #1 chk("reset_mid_held", act(), X_ZERO);
        reset = 1'b0;
        #1 chk("post_reset_init", act(), X_ZERO);
        @(negedge clk); #1 chk("post_reset_if", act(), X_IF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle MIPS main controller: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback cycles. It sits directly upstream of the datapath ALU and drives that ALU's `ALUConf[4:0]` and `Sign` inputs plus all datapath mux and write-enable controls. It also consumes the ALU's `Zero` and `overflow` outputs to resolve branches and to suppress writeback on signed overflow.

## Interface
Parameters:
- none; the opcode and funct encodings are the fixed MIPS-I values listed under Operation.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `OpCode`  in  6  `IR[31:26]`; valid from the ID state onward.
- `Funct`  in  6  `IR[5:0]`; valid from the ID state onward.
- `Zero`  in  1  ALU result-equals-zero flag.
- `overflow`  in  1  ALU raw overflow flag.
- `PCWrite`  out  1  PC load enable; branch resolution is already folded in.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemRead`  out  1  memory read enable.
- `MemWrite`  out  1  memory write enable.
- `IRWrite`  out  1  instruction register load enable.
- `RegWrite`  out  1  register file write enable.
- `RegDst`  out  2  write-register select: 0 = rt, 1 = rd, 2 = $31.
- `MemtoReg`  out  2  write-data select: 0 = ALUOut, 1 = MDR, 2 = PC.
- `ALUSrcA`  out  2  ALU In1 select: 0 = PC, 1 = A, 2 = shamt.
- `ALUSrcB`  out  2  ALU In2 select: 0 = B, 1 = 4, 2 = ext(imm), 3 = ext(imm)<<2.
- `PCSource`  out  2  next-PC select: 0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = A.
- `ExtOp`  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
- `LuiOp`  out  1  immediate is replaced by `{imm,16'h0}`.
- `ALUConf`  out  5  ALU operation select.
- `Sign`  out  1  ALU signed-compare select.
- `ovf_exc`  out  1  one-cycle pulse: a signed add/sub overflowed and its writeback was suppressed.
- `illegal_op`  out  1  one-cycle pulse in ID when the instruction does not decode.

## Operation
- **Outputs.** All outputs are pure decodes of the state register, the latched overflow bit `ovf_q` and the `OpCode`/`Funct` inputs.
  - Any output not listed for a state is 0.
  - `ALUConf` defaults to 00000.
- **State register.** 4 bits wide; the states are listed below.
- **INIT:** all outputs 0. Next state is IF.
- **IF:**
  - `MemRead`=1, `IorD`=0, `IRWrite`=1.
  - `ALUSrcA`=0, `ALUSrcB`=1, `ALUConf` = add, `Sign`=0.
  - `PCSource`=0, `PCWrite`=1.
  - Next state is ID.
- **ID:**
  - Computes the branch target: `ALUSrcA`=0, `ALUSrcB`=3, add, `ExtOp`=1.
  - Dispatch on opcode:
    - lw/sw → MADDR
    - R-type → REX, except jr/jalr → JR
    - beq → BR
    - j/jal → JMP
    - addi/addiu/andi/ori/xori/slti/sltiu/lui → IEX
    - anything else → `illegal_op`=1, next state IF.
- **MADDR:** `ALUSrcA`=1, `ALUSrcB`=2, `ExtOp`=1, add, `Sign`=0. Next state is MRD for lw, MWR for sw.
- **MRD:** `MemRead`=1, `IorD`=1. Next state is MWB.
- **MWB:** `RegWrite`=1, `RegDst`=0, `MemtoReg`=1. Next state is IF.
- **MWR:** `MemWrite`=1, `IorD`=1. Next state is IF.
- **REX:**
  - `ALUSrcA` = 2 for sll/srl/sra, otherwise 1. `ALUSrcB`=0.
  - ALU function per funct:
    - add 0x20 / addu 0x21 → 00000
    - sub 0x22 / subu 0x23 → 00110
    - and 0x24 → 00010
    - or 0x25 → 00001
    - xor 0x26 → 01101
    - nor 0x27 → 01100
    - slt 0x2a / sltu 0x2b → 00111
    - sll 0x00 → 11001
    - srl 0x02 → 10000
    - sra 0x03 → 11000
  - `Sign`=1 only for add, sub and slt.
  - Any other funct is illegal: `illegal_op`=1 and next state is IF.
  - Otherwise next state is RWB.
- **RWB:** `RegDst`=1, `MemtoReg`=0, `RegWrite` = ~`ovf_q`, `ovf_exc` = `ovf_q`. Next state is IF.
- **IEX:**
  - `ALUSrcA`=1, `ALUSrcB`=2.
  - ALU function and extension per opcode:

    | Opcode | ALU op | `ExtOp` | `LuiOp` | `Sign` |
    |---|---|---|---|---|
    | addi 0x08 | add | 1 | 0 | 1 |
    | addiu 0x09 | add | 1 | 0 | 0 |
    | andi 0x0c | and | 0 | 0 | 0 |
    | ori 0x0d | or | 0 | 0 | 0 |
    | xori 0x0e | xor | 0 | 0 | 0 |
    | slti 0x0a | slt | 1 | 0 | 1 |
    | sltiu 0x0b | slt | 1 | 0 | 0 |
    | lui 0x0f | add, In1 = A of $0 | 0 | 1 | 0 |

  - Next state is IWB.
- **IWB:** `RegDst`=0, `MemtoReg`=0, `RegWrite` = ~`ovf_q`, `ovf_exc` = `ovf_q`. Next state is IF.
- **BR:** `ALUSrcA`=1, `ALUSrcB`=0, sub, `Sign`=0, `PCSource`=1, `PCWrite` = `Zero`. Next state is IF.
- **JMP:**
  - `PCSource`=2, `PCWrite`=1.
  - For jal additionally: `RegWrite`=1, `RegDst`=2, `MemtoReg`=2.
  - Next state is IF.
- **JR:**
  - `PCSource`=3, `PCWrite`=1.
  - For jalr additionally: `RegWrite`=1, `RegDst`=1, `MemtoReg`=2.
  - Next state is IF.
- **Overflow latch.**
  - In REX and IEX, `ovf_q` <= `overflow` & `Sign` & (`ALUConf` is 00000 or 00110).
  - In all other states, `ovf_q` <= 0.
  - Address, PC+4, unsigned and logical operations therefore never flag overflow.

## Timing
- **Reset.** `reset` high forces the state to INIT and `ovf_q` to 0 immediately (asynchronous). All outputs read 0 during reset, including `PCWrite` and `RegWrite`.
- **After reset release.** First rising edge moves INIT→IF. The first fetch completes on the second edge.
- **Cycles per instruction:**
  - lw: 5
  - R-type, I-type ALU, sw: 4
  - beq, j, jal, jr, jalr: 3
  - illegal instruction: 2
  - INIT is visited once only.
- **Branch timing.** `Zero` is sampled combinationally in BR. The PC loads on the BR→IF edge only if `Zero`=1.
- **Overflow timing.** `overflow` is sampled only on the REX/IEX→WB edge. Changes in the WB cycle are ignored.
- **Reset mid-instruction.** Any state returns to INIT with no partial write: `RegWrite`/`MemWrite` drop asynchronously.
- **No stalls.** There is no handshake; memory is single-cycle.

## Test plan
- **Reset and fetch.** Assert `reset` mid-MRD.
  - Required during reset: all outputs 0.
  - After release: INIT for 1 cycle, then IF with `PCWrite`=1, `IRWrite`=1, `ALUConf`=00000.
- **add overflow.** add with A=0x7FFFFFFF, B=1 (`overflow`=1 in REX).
  - Required in RWB: `RegWrite`=0, `ovf_exc`=1.
  - Same operands with addu: `RegWrite`=1, `ovf_exc`=0.
- **beq.** beq with `Zero`=1 in BR: `PCWrite`=1, `PCSource`=1. Repeat with `Zero`=0: `PCWrite`=0. Each takes 3 cycles.
- **lw sequence.** Required state order IF, ID, MADDR, MRD, MWB.
  - In MWB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0.
  - Next IF at cycle 6.
- **Shifts.** sra funct 0x03 in REX: `ALUSrcA`=2, `ALUConf`=11000. sltiu in IEX: `ALUConf`=00111, `Sign`=0, `ExtOp`=1.
- **Illegal and jumps.** OpCode 0x3F in ID: `illegal_op`=1 for one cycle, next state IF. jal in JMP: `RegDst`=2, `MemtoReg`=2, `PCSource`=2.
